// File: rtl/clock_div_checker.sv
// Measures period and high time of a divided clock in clk_in cycles; reports lock, per-measurement quality and sticky errors.
// Define CLOCK_DIV_CHECKER_SYNC_EN to put a 2-flop synchronizer ahead of the sample register (clk_div not derived from clk_in).
module clock_div_checker #(
  parameter int DIV_RATIO  = 6,
  parameter int HIGH_EXP   = DIV_RATIO / 2,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clk_div,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             meas_good,
  output logic             locked,
  output logic             err
);

  localparam int GW     = $clog2(LOCK_COUNT + 1);
  localparam int P_LO_I = (DIV_RATIO > TOL) ? DIV_RATIO - TOL : 0;
  localparam int H_LO_I = (HIGH_EXP > TOL) ? HIGH_EXP - TOL : 0;

  localparam logic [CNT_W-1:0] P_LO      = CNT_W'(P_LO_I);
  localparam logic [CNT_W-1:0] P_HI      = CNT_W'(DIV_RATIO + TOL);
  localparam logic [CNT_W-1:0] H_LO      = CNT_W'(H_LO_I);
  localparam logic [CNT_W-1:0] H_HI      = CNT_W'(HIGH_EXP + TOL);
  localparam logic [CNT_W-1:0] STALL_THR = CNT_W'(2 * DIV_RATIO + TOL);
  localparam logic [CNT_W-1:0] SAT       = '1;
  localparam logic [GW-1:0]    LOCK_C    = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic             samp, s, s_d, rise, fall;
  logic [CNT_W-1:0] pcnt, pcnt_nxt, hcnt, hcnt_nxt;
  logic [CNT_W-1:0] period_nxt, high_time_nxt;
  logic             fall_seen, fall_seen_nxt;
  logic [GW-1:0]    gcnt, gcnt_nxt, gcnt_inc;
  logic             mv_nxt, mg_nxt, lk_nxt, err_set, err_nxt;
  logic             meas_ok, stall;

`ifdef CLOCK_DIV_CHECKER_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk_in) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], clk_div};
  end

  assign samp = sync[1];
`else
  assign samp = clk_div;
`endif

  assign rise     = s & ~s_d;
  assign fall     = ~s & s_d;
  assign gcnt_inc = gcnt + 1'b1;
  assign stall    = (pcnt >= STALL_THR);

  // A rise without a fall since the previous rise, or a saturated period, is never good.
  assign meas_ok = fall_seen && (pcnt != SAT) &&
                   (pcnt >= P_LO) && (pcnt <= P_HI) &&
                   (high_time >= H_LO) && (high_time <= H_HI);

  always_comb begin
    state_nxt     = state;
    gcnt_nxt      = gcnt;
    period_nxt    = period;
    mv_nxt        = 1'b0;
    mg_nxt        = 1'b0;
    lk_nxt        = locked;
    err_set       = 1'b0;
    pcnt_nxt      = (pcnt == SAT) ? pcnt : pcnt + 1'b1;
    hcnt_nxt      = hcnt;
    fall_seen_nxt = fall_seen;
    high_time_nxt = high_time;

    if (rise) begin
      pcnt_nxt      = 1;
      hcnt_nxt      = 1;
      fall_seen_nxt = 1'b0;
    end else begin
      if (s && (hcnt != SAT)) hcnt_nxt = hcnt + 1'b1;
      if (fall) begin
        fall_seen_nxt = 1'b1;
        high_time_nxt = hcnt;
      end
    end

    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEASURE;
          gcnt_nxt  = '0;
        end
      end
      MEASURE, LOCKED: begin
        // A rise on the stall-threshold cycle is a measurement, not a stall.
        if (rise) begin
          period_nxt = pcnt;
          mv_nxt     = 1'b1;
          mg_nxt     = meas_ok;
          if (!meas_ok) begin
            err_set   = 1'b1;
            lk_nxt    = 1'b0;
            state_nxt = MEASURE;
            gcnt_nxt  = '0;
          end else if (state == MEASURE) begin
            gcnt_nxt = gcnt_inc;
            if (gcnt_inc == LOCK_C) begin
              state_nxt = LOCKED;
              lk_nxt    = 1'b1;
            end
          end
        end else if (stall) begin
          err_set   = 1'b1;
          lk_nxt    = 1'b0;
          state_nxt = IDLE;
          gcnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gcnt_nxt  = '0;
        lk_nxt    = 1'b0;
      end
    endcase

    err_nxt = err_set | (err & ~err_clr);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      s          <= 1'b0;
      s_d        <= 1'b0;
      pcnt       <= '0;
      hcnt       <= '0;
      fall_seen  <= 1'b0;
      gcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      meas_good  <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      s          <= samp;
      s_d        <= s;
      pcnt       <= pcnt_nxt;
      hcnt       <= hcnt_nxt;
      fall_seen  <= fall_seen_nxt;
      gcnt       <= gcnt_nxt;
      period     <= period_nxt;
      high_time  <= high_time_nxt;
      meas_valid <= mv_nxt;
      meas_good  <= mg_nxt;
      locked     <= lk_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_clock_div_checker.sv
// Directed bench for clock_div_checker: /6 checker (lock, bad period, stall, err_clr, reset) and a /3 checker.
module tb_clock_div_checker;

`ifdef CLOCK_DIV_CHECKER_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk_in, reset, clk_div, err_clr, clk_div3, err_clr3;
  logic [7:0] period, high_time, period3, high_time3;
  logic       meas_valid, meas_good, locked, err;
  logic       meas_valid3, meas_good3, locked3, err3;

  int checks   = 0;
  int failures = 0;

  // Values captured at the meas_valid pulse inside one driven period.
  int         mv_n, mv_at;
  logic [7:0] per_o, ht_o;
  logic       good_o, lk_o, er_o;

  clock_div_checker #(.DIV_RATIO(6), .HIGH_EXP(3), .TOL(0), .LOCK_COUNT(4), .CNT_W(8)) dut (
    .clk_in(clk_in), .reset(reset), .clk_div(clk_div), .err_clr(err_clr),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .meas_good(meas_good), .locked(locked), .err(err)
  );

  clock_div_checker #(.DIV_RATIO(3), .HIGH_EXP(1), .TOL(0), .LOCK_COUNT(4), .CNT_W(8)) dut3 (
    .clk_in(clk_in), .reset(reset), .clk_div(clk_div3), .err_clr(err_clr3),
    .period(period3), .high_time(high_time3), .meas_valid(meas_valid3),
    .meas_good(meas_good3), .locked(locked3), .err(err3)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // One clk_div period: h cycles high then l low; err_clr pulsed on cycle clr_idx (0 = never).
  task automatic drive_period(input int h, input int l, input int clr_idx);
    mv_n = 0; mv_at = 0;
    clk_div = 1'b1;
    for (int i = 1; i <= h + l; i++) begin
      err_clr = (i == clr_idx);
      step();
      if (meas_valid) begin
        mv_n++; mv_at = i;
        per_o = period; ht_o = high_time; good_o = meas_good; lk_o = locked; er_o = err;
      end
      if (i == h) clk_div = 1'b0;
    end
    err_clr = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high_time"}, high_time, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_meas_good"}, meas_good, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int err_at, extra_mv, n3, first3, bad3, lk3_at3, lk3_at4, lk3_last;

    reset = 1'b1; clk_div = 1'b0; err_clr = 1'b0; clk_div3 = 1'b0; err_clr3 = 1'b0;
    repeat (3) step();
    chk_reset_state("rst");
    reset = 1'b0;
    repeat (3) step();

    // Clean /6: first rise arms, next four rises measure; lock with the 4th.
    drive_period(3, 3, 0);
    chk("first_rise_mv", mv_n, 0);
    for (int k = 0; k < 3; k++) begin
      drive_period(3, 3, 0);
      chk("clean_mv_count", mv_n, 1);
      chk("clean_latency", mv_at, LAT);
      chk("clean_period", per_o, 6);
      chk("clean_high_time", ht_o, 3);
      chk("clean_good", good_o, 1);
      chk("clean_not_locked", lk_o, 0);
    end
    drive_period(3, 3, 0);
    chk("lock_4th", lk_o, 1);
    chk("lock_err", er_o, 0);

    // Shortened period of 5.
    drive_period(3, 2, 0);
    chk("pre_short_good", good_o, 1);
    drive_period(3, 3, 0);
    chk("short_period", per_o, 5);
    chk("short_good", good_o, 0);
    chk("short_locked", lk_o, 0);
    chk("short_err", er_o, 1);
    for (int k = 0; k < 3; k++) drive_period(3, 3, 0);
    chk("relock_3rd", lk_o, 0);
    drive_period(3, 3, 0);
    chk("relock_4th", lk_o, 1);
    chk("err_sticky", err, 1);

    // err_clr alone, then err_clr coincident with a bad measurement.
    drive_period(3, 3, 1);
    chk("clr_alone_mv_err", er_o, 0);
    chk("clr_alone_err", err, 0);
    drive_period(3, 2, 0);
    chk("pre_coinc_err", err, 0);
    drive_period(3, 3, LAT);
    chk("coinc_good", good_o, 0);
    chk("coinc_err", er_o, 1);
    chk("coinc_locked", lk_o, 0);
    drive_period(3, 3, 1);
    for (int k = 0; k < 3; k++) drive_period(3, 3, 0);
    chk("relock2", lk_o, 1);
    chk("relock2_err", err, 0);

    // Stall: hold clk_div high after lock.
    err_at = 0; extra_mv = 0;
    clk_div = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (meas_valid && i > LAT) extra_mv++;
      if (err && err_at == 0) err_at = i;
    end
    chk("stall_err_at", err_at, LAT + 12);
    chk("stall_no_mv", extra_mv, 0);
    chk("stall_locked", locked, 0);
    clk_div = 1'b0;
    repeat (3) step();
    drive_period(3, 3, 0);
    chk("stall_rearm_mv", mv_n, 0);
    for (int k = 0; k < 3; k++) drive_period(3, 3, 0);
    chk("stall_relock_3rd", lk_o, 0);
    drive_period(3, 3, 0);
    chk("stall_relock_4th", lk_o, 1);

    // Reset while locked.
    reset = 1'b1;
    step();
    chk_reset_state("midrst");
    reset = 1'b0;
    drive_period(3, 3, 0);
    chk("post_rst_first_mv", mv_n, 0);
    for (int k = 0; k < 3; k++) drive_period(3, 3, 0);
    chk("post_rst_3rd", lk_o, 0);
    drive_period(3, 3, 0);
    chk("post_rst_lock", lk_o, 1);
    chk("post_rst_period", per_o, 6);

    // /3 divider, 1 high / 2 low, eight rises.
    n3 = 0; first3 = -1; bad3 = 0; lk3_at3 = -1; lk3_at4 = -1; lk3_last = -1;
    for (int c = 0; c <= 26; c++) begin
      clk_div3 = (c < 24) && (c % 3 == 0);
      step();
      if (meas_valid3) begin
        n3++;
        if (n3 == 1) first3 = c;
        if (period3 != 8'd3 || high_time3 != 8'd1 || !meas_good3 || err3) bad3++;
        if (n3 == 3) lk3_at3 = int'(locked3);
        if (n3 == 4) lk3_at4 = int'(locked3);
        if (n3 == 7) lk3_last = int'(locked3);
      end
    end
    chk("div3_mv_count", n3, 7);
    chk("div3_first_mv", first3, LAT + 2);
    chk("div3_bad_meas", bad3, 0);
    chk("div3_lock_3rd", lk3_at3, 0);
    chk("div3_lock_4th", lk3_at4, 1);
    chk("div3_lock_last", lk3_last, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
